ct_split: RTL and testbench
===========================

// Module: ct_split
// PURPOSE
//  Packet-aware 1:NO demultiplexer. Routes a ready/valid/eop stream to one of NO outputs, selected by i_dest.
//  The destination is sampled on a packet's first beat and held until its eop beat, so packets never interleave.
//  Counterpart of the round-robin merge: fans one channel out to NO endpoints, whereas the merge fans NO in to one.
//  One registered beat stage breaks the data/valid path; ready is combinational.
// PARAMETERS
//  NO     2  number of output ports (>=1)
//  WIDTH  8  data width per beat
//  NOBITS    localparam = max(1, ceil(log2(NO))); width of i_dest
// PORTS
//  clk      in   1         clock, all state updates on rising edge
//  reset_n  in   1         asynchronous reset, active low
//  i_data   in   WIDTH     input beat data
//  i_valid  in   1         input beat valid
//  o_ready  out  1         input ready; beat accepted when i_valid && o_ready
//  i_eop    in   1         input end-of-packet
//  i_dest   in   NOBITS    destination port; sampled only on a packet's first beat
//  o_data   out  NO*WIDTH  held data replicated on every lane k ([k*WIDTH +: WIDTH])
//  o_valid  out  NO        one-hot-or-zero; bit k = stage full && held_dest==k
//  i_ready  in   NO        per-output ready; beat leaves on o_valid[k] && i_ready[k]
//  o_eop    out  NO        held eop replicated on every lane; meaningful only where o_valid set
// BEHAVIOUR
//  Reset (async, reset_n=0): stage empty, state S_HEAD, locked_dest=0, o_valid=0, o_data=0, o_eop=0.
//   o_ready=1 once reset_n deasserts.
//  Stage: one register {data, eop, dest, full}. Latency: accepted beat appears on o_valid at next edge.
//  o_ready = !full || i_ready[held_dest]. Drain and refill in the same cycle: 1 beat/cycle sustained.
//  i_ready bits of non-selected outputs are ignored. o_valid/o_data/o_eop stay stable while stalled.
//  Effective dest: i_dest in S_HEAD, locked_dest in S_BODY.
//  FSM:
//   S_HEAD  accept && !i_eop -> S_BODY, locked_dest <= i_dest. accept && i_eop -> stay (1-beat packet).
//   S_BODY  accept && i_eop -> S_HEAD. i_dest ignored, even if it changes mid-packet.
//  Out-of-range dest (i_dest >= NO, non-power-of-2 NO), macro absent: packet routed to output 0.
//  No-accept cycle (i_valid=0 or o_ready=0): no state change; bubbles mid-packet keep the lock.
//  Reset mid-packet: partial packet abandoned and held beat lost; next accepted beat is a new packet head.
//  NO=1: i_dest ignored; the block is a one-stage packet pipeline register.
// CONFIGURATION
//  CT_SPLIT_DROP_EN defined: a packet whose head i_dest >= NO is discarded whole.
//   - Head is flagged; FSM enters S_BODY with a drop flag, or stays S_HEAD if head has eop.
//   - Every beat of the packet is consumed with o_ready=1, independent of stage occupancy.
//   - Stage is never loaded; an already-held beat drains normally.
//  CT_SPLIT_DROP_EN undefined: no drop logic; out-of-range packets go to output 0 as above.
// TESTING
//  1 NO=4,WIDTH=8: 3-beat pkt dest=2 (A0,A1,A2+eop), all i_ready=1 -> o_valid=4'b0100 cycles 1..3,
//    o_eop high on A2 only.
//  2 Mid-packet i_dest change 2->1 on beat 2 -> all beats still exit port 2; next packet follows new i_dest.
//  3 Backpressure: i_ready[2]=0 for 3 cycles with stage full -> o_ready=0, o_data stable;
//    i_ready[1]=1 has no effect; release -> 1 beat/cycle.
//  4 Back-to-back 1-beat pkts dest 0,3,1,3 with i_valid held high -> o_valid 0001,1000,0010,1000
//    on consecutive cycles; FSM stays S_HEAD.
//  5 reset_n low while S_BODY after beat 1 of 4 -> o_valid=0 at once;
//    after release next beat uses its own i_dest as a head.
//  6 NO=3, head dest=3, 2-beat pkt: macro off -> exits port 0;
//    CT_SPLIT_DROP_EN -> both beats accepted, o_valid stays 0, next dest=1 pkt delivered intact.

Source files
------------

// File: rtl/ct_split.sv
// ct_split: packet-aware 1:NO demultiplexer with a single registered beat stage.
// Optional build macro CT_SPLIT_DROP_EN discards whole packets whose head destination is out of range.
module ct_split #(
  parameter  int NO     = 2,
  parameter  int WIDTH  = 8,
  localparam int NOBITS = (NO > 1) ? $clog2(NO) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    i_data,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_eop,
  input  logic [NOBITS-1:0]   i_dest,
  output logic [NO*WIDTH-1:0] o_data,
  output logic [NO-1:0]       o_valid,
  input  logic [NO-1:0]       i_ready,
  output logic [NO-1:0]       o_eop
);

  typedef enum logic {
    S_HEAD = 1'b0,
    S_BODY = 1'b1
  } state_t;

  state_t            state_r;
  logic [NOBITS-1:0] locked_dest_r;
  logic [NOBITS-1:0] dest_r;
  logic [WIDTH-1:0]  data_r;
  logic              eop_r;
  logic              full_r;
`ifdef CT_SPLIT_DROP_EN
  logic              drop_r;
`endif

  logic              in_range_s;
  logic [NOBITS-1:0] head_dest_s;
  logic [NOBITS-1:0] eff_dest_s;
  logic              drop_s;
  logic              drain_s;
  logic              ready_s;
  logic              accept_s;
  logic              load_s;

  // Destination resolution, drop decision and stage handshake.
  always_comb begin
    if (NO == 1) begin
      in_range_s = 1'b1;
    end else begin
      in_range_s = (32'(i_dest) < NO);
    end

    // With one output the destination field carries no information.
    if ((NO > 1) && in_range_s) begin
      head_dest_s = i_dest;
    end else begin
      head_dest_s = {NOBITS{1'b0}};
    end

    if (state_r == S_BODY) begin
      eff_dest_s = locked_dest_r;
    end else begin
      eff_dest_s = head_dest_s;
    end

`ifdef CT_SPLIT_DROP_EN
    if (state_r == S_BODY) begin
      drop_s = drop_r;
    end else begin
      drop_s = !in_range_s;
    end
`else
    drop_s = 1'b0;
`endif

    drain_s  = full_r && i_ready[dest_r];
    // Dropped beats are swallowed regardless of what the stage is doing.
    ready_s  = drop_s || !full_r || i_ready[dest_r];
    accept_s = i_valid && ready_s;
    load_s   = accept_s && !drop_s;
  end

  // Beat stage: refill takes priority so drain and load can share a cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_r <= 1'b0;
      data_r <= {WIDTH{1'b0}};
      eop_r  <= 1'b0;
      dest_r <= {NOBITS{1'b0}};
    end else if (load_s) begin
      full_r <= 1'b1;
      data_r <= i_data;
      eop_r  <= i_eop;
      dest_r <= eff_dest_s;
    end else if (drain_s) begin
      full_r <= 1'b0;
    end
  end

  // Packet framing FSM: lock destination on head, release on eop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= S_HEAD;
      locked_dest_r <= {NOBITS{1'b0}};
`ifdef CT_SPLIT_DROP_EN
      drop_r        <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_HEAD: begin
          if (accept_s && !i_eop) begin
            state_r       <= S_BODY;
            locked_dest_r <= head_dest_s;
`ifdef CT_SPLIT_DROP_EN
            drop_r        <= !in_range_s;
`endif
          end
        end
        S_BODY: begin
          if (accept_s && i_eop) begin
            state_r <= S_HEAD;
`ifdef CT_SPLIT_DROP_EN
            drop_r  <= 1'b0;
`endif
          end
        end
        default: begin
          state_r <= S_HEAD;
        end
      endcase
    end
  end

  // Output lane decode from the held beat.
  always_comb begin
    o_valid = {NO{1'b0}};
    for (int k = 0; k < NO; k++) begin
      o_valid[k] = full_r && (dest_r == NOBITS'(k));
    end
  end

  assign o_data  = {NO{data_r}};
  assign o_eop   = {NO{eop_r}};
  assign o_ready = ready_s;

endmodule

// File: tb/tb_ct_split.sv
// Scoreboard bench for ct_split: a NO=4 instance for routing/backpressure/reset,
// and a NO=3 instance for out-of-range heads (expectations follow CT_SPLIT_DROP_EN).
`timescale 1ns/1ps
module tb_ct_split;
`ifdef CT_SPLIT_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0]  a_data;
  logic        a_valid, a_eop, a_rdy;
  logic [1:0]  a_dest;
  logic [31:0] a_odata;
  logic [3:0]  a_ovalid, a_iready, a_oeop;

  logic [7:0]  b_data;
  logic        b_valid, b_eop, b_rdy;
  logic [1:0]  b_dest;
  logic [23:0] b_odata;
  logic [2:0]  b_ovalid, b_iready, b_oeop;

  ct_split #(.NO(4), .WIDTH(8)) u_dut4 (
    .clk(clk), .reset_n(rst_n), .i_data(a_data), .i_valid(a_valid), .o_ready(a_rdy),
    .i_eop(a_eop), .i_dest(a_dest), .o_data(a_odata), .o_valid(a_ovalid),
    .i_ready(a_iready), .o_eop(a_oeop)
  );

  ct_split #(.NO(3), .WIDTH(8)) u_dut3 (
    .clk(clk), .reset_n(rst_n), .i_data(b_data), .i_valid(b_valid), .o_ready(b_rdy),
    .i_eop(b_eop), .i_dest(b_dest), .o_data(b_odata), .o_valid(b_ovalid),
    .i_ready(b_iready), .o_eop(b_oeop)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [1:0] port;
    logic [7:0] data;
    logic       eop;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  logic       ma_in_pkt = 1'b0;
  logic [1:0] ma_port   = 2'd0;
  logic       mb_in_pkt = 1'b0;
  logic       mb_drop   = 1'b0;
  logic [1:0] mb_port   = 2'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard for the NO=4 instance: pop on output handshake, push on input accept.
  always @(negedge clk) begin
    beat_t e;
    int    p;
    if (!rst_n) begin
      qa.delete();
      ma_in_pkt = 1'b0;
    end else begin
      if (|(a_ovalid & a_iready)) begin
        p = 0;
        for (int k = 0; k < 4; k++) if (a_ovalid[k]) p = k;
        if (qa.size() == 0) begin
          check("a_unexpected_beat", 32'(a_ovalid), 32'd0);
        end else begin
          e = qa.pop_front();
          check("a_ovalid", 32'(a_ovalid), 32'd1 << e.port);
          check("a_data", 32'(a_odata[p*8 +: 8]), 32'(e.data));
          check("a_eop", 32'(a_oeop[p]), 32'(e.eop));
        end
      end
      if (a_valid && a_rdy) begin
        if (!ma_in_pkt) ma_port = a_dest;
        qa.push_back(beat_t'{ma_port, a_data, a_eop});
        ma_in_pkt = !a_eop;
      end
    end
  end

  // Scoreboard for the NO=3 instance, including out-of-range head handling.
  always @(negedge clk) begin
    beat_t e;
    int    p;
    if (!rst_n) begin
      qb.delete();
      mb_in_pkt = 1'b0;
      mb_drop   = 1'b0;
    end else begin
      if (|(b_ovalid & b_iready)) begin
        p = 0;
        for (int k = 0; k < 3; k++) if (b_ovalid[k]) p = k;
        if (qb.size() == 0) begin
          check("b_unexpected_beat", 32'(b_ovalid), 32'd0);
        end else begin
          e = qb.pop_front();
          check("b_ovalid", 32'(b_ovalid), 32'd1 << e.port);
          check("b_data", 32'(b_odata[p*8 +: 8]), 32'(e.data));
          check("b_eop", 32'(b_oeop[p]), 32'(e.eop));
        end
      end
      if (b_valid && b_rdy) begin
        if (!mb_in_pkt) begin
          mb_drop = DROP && (b_dest >= 2'd3);
          mb_port = (b_dest >= 2'd3) ? 2'd0 : b_dest;
        end
        if (!mb_drop) qb.push_back(beat_t'{mb_port, b_data, b_eop});
        mb_in_pkt = !b_eop;
      end
    end
  end

  task automatic send_a(input logic [7:0] d, input logic e, input logic [1:0] dst, output int waits);
    bit acc;
    waits = 0;
    acc = 1'b0;
    a_data = d; a_eop = e; a_dest = dst; a_valid = 1'b1;
    while (!acc && waits <= 50) begin
      @(negedge clk);
      acc = a_rdy;
      @(posedge clk);
      #1;
      if (!acc) waits++;
    end
    if (!acc) check("a_send_timeout", 32'd0, 32'd1);
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input logic e, input logic [1:0] dst, output int waits);
    bit acc;
    waits = 0;
    acc = 1'b0;
    b_data = d; b_eop = e; b_dest = dst; b_valid = 1'b1;
    while (!acc && waits <= 50) begin
      @(negedge clk);
      acc = b_rdy;
      @(posedge clk);
      #1;
      if (!acc) waits++;
    end
    if (!acc) check("b_send_timeout", 32'd0, 32'd1);
    b_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    rst_n = 1'b0;
    a_data = 8'd0; a_valid = 1'b0; a_eop = 1'b0; a_dest = 2'd0; a_iready = 4'b1111;
    b_data = 8'd0; b_valid = 1'b0; b_eop = 1'b0; b_dest = 2'd0; b_iready = 3'b111;

    #12;
    check("rst_a_ovalid", 32'(a_ovalid), 32'd0);
    check("rst_a_odata", a_odata, 32'd0);
    check("rst_a_oeop", 32'(a_oeop), 32'd0);
    check("rst_b_ovalid", 32'(b_ovalid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_a_ready", 32'(a_rdy), 32'd1);
    check("rst_b_ready", 32'(b_rdy), 32'd1);
    @(posedge clk); #1;

    // 3-beat packet to port 2
    send_a(8'hA0, 1'b0, 2'd2, w);
    check("t1_ovalid_a0", 32'(a_ovalid), 32'h4);
    check("t1_eop_a0", 32'(a_oeop[2]), 32'd0);
    send_a(8'hA1, 1'b0, 2'd2, w);
    check("t1_ovalid_a1", 32'(a_ovalid), 32'h4);
    send_a(8'hA2, 1'b1, 2'd2, w);
    check("t1_ovalid_a2", 32'(a_ovalid), 32'h4);
    check("t1_eop_a2", 32'(a_oeop[2]), 32'd1);
    check("t1_data_a2", 32'(a_odata[23:16]), 32'hA2);

    // destination changes mid-packet
    send_a(8'h20, 1'b0, 2'd2, w);
    send_a(8'h21, 1'b0, 2'd1, w);
    check("t2_locked", 32'(a_ovalid), 32'h4);
    send_a(8'h22, 1'b1, 2'd1, w);
    check("t2_locked_eop", 32'(a_ovalid), 32'h4);
    send_a(8'h23, 1'b1, 2'd1, w);
    check("t2_new_head", 32'(a_ovalid), 32'h2);

    // backpressure on port 2, port 1 ready must not matter
    a_iready = 4'b1011;
    send_a(8'hB0, 1'b0, 2'd2, w);
    a_data = 8'hB1; a_eop = 1'b0; a_dest = 2'd2; a_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t3_ready_low", 32'(a_rdy), 32'd0);
      check("t3_data_hold", 32'(a_odata[23:16]), 32'hB0);
      check("t3_ovalid_hold", 32'(a_ovalid), 32'h4);
    end
    @(posedge clk); #1;
    a_iready = 4'b1111;
    send_a(8'hB1, 1'b0, 2'd2, w);
    check("t3_rate_b1", 32'(w), 32'd0);
    send_a(8'hB2, 1'b1, 2'd2, w);
    check("t3_rate_b2", 32'(w), 32'd0);

    // back-to-back single-beat packets
    send_a(8'hC0, 1'b1, 2'd0, w);
    check("t4_ov0", 32'(a_ovalid), 32'h1);
    send_a(8'hC1, 1'b1, 2'd3, w);
    check("t4_ov1", 32'(a_ovalid), 32'h8);
    check("t4_rate1", 32'(w), 32'd0);
    send_a(8'hC2, 1'b1, 2'd1, w);
    check("t4_ov2", 32'(a_ovalid), 32'h2);
    check("t4_rate2", 32'(w), 32'd0);
    send_a(8'hC3, 1'b1, 2'd3, w);
    check("t4_ov3", 32'(a_ovalid), 32'h8);
    check("t4_rate3", 32'(w), 32'd0);
    @(posedge clk); #1;

    // reset in the middle of a packet
    send_a(8'h50, 1'b0, 2'd2, w);
    rst_n = 1'b0;
    #1;
    check("t5_async_clear", 32'(a_ovalid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_a(8'h51, 1'b1, 2'd1, w);
    check("t5_new_head", 32'(a_ovalid), 32'h2);

    // out-of-range head on the NO=3 instance
    send_b(8'h60, 1'b0, 2'd3, w);
    check("t6_acc0", 32'(w), 32'd0);
    check("t6_ov0", 32'(b_ovalid), DROP ? 32'd0 : 32'd1);
    send_b(8'h61, 1'b1, 2'd3, w);
    check("t6_acc1", 32'(w), 32'd0);
    check("t6_ov1", 32'(b_ovalid), DROP ? 32'd0 : 32'd1);
    send_b(8'h70, 1'b0, 2'd1, w);
    check("t6_next0", 32'(b_ovalid), 32'h2);
    send_b(8'h71, 1'b1, 2'd1, w);
    check("t6_next1", 32'(b_ovalid), 32'h2);
    check("t6_next_data", 32'(b_odata[15:8]), 32'h71);

    repeat (4) @(posedge clk);
    #1;
    check("a_queue_empty", 32'(qa.size()), 32'd0);
    check("b_queue_empty", 32'(qb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
